// File: rtl/m_dram_port_arbiter_pkg.sv
// Shared requester IDs, FSM encodings and helpers for the DRAM port arbiter.
// State codes are plain 2-bit constants so they line up with the legacy encodings.
package m_dram_port_arbiter_pkg;

  localparam logic [1:0] ARB_PTE  = 2'd0;
  localparam logic [1:0] ARB_CPU  = 2'd1;
  localparam logic [1:0] ARB_DMA  = 2'd2;
  localparam logic [1:0] ARB_NONE = 2'd3;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  // One-hot ack vector for a requester ID; ARB_NONE maps to no ack.
  function automatic logic [2:0] arb_onehot(input logic [1:0] id);
    logic [2:0] v;
    v = '0;
    if (id != ARB_NONE) v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/m_dram_port_arbiter_rr.sv
// Two-way round-robin picker for the CPU/DMA pair.
// ptr=0 prefers req[0] (CPU), ptr=1 prefers req[1] (DMA) when both are requesting.
module m_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) gnt = ptr ? 2'b10 : 2'b01;
    else if (req[0])      gnt = 2'b01;
    else if (req[1])      gnt = 2'b10;
  end

endmodule

// File: rtl/m_dram_port_arbiter.sv
// Shares the single DRAM controller port between the PTE walker, CPU and DMA.
// Fixed priority for the PTE walker, round-robin between CPU and DMA, WAIT watchdog.
module m_dram_port_arbiter
  import m_dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        w_req,
  input  logic [ADDR_W-1:0] w_addr0,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [ADDR_W-1:0] w_addr2,
  input  logic [2:0]        w_we,
  input  logic [DATA_W-1:0] w_wdata0,
  input  logic [DATA_W-1:0] w_wdata1,
  input  logic [DATA_W-1:0] w_wdata2,
  input  logic [2:0]        w_ctrl0,
  input  logic [2:0]        w_ctrl1,
  input  logic [2:0]        w_ctrl2,
  output logic [2:0]        w_ack,
  output logic [DATA_W-1:0] w_rdata,
  output logic [1:0]        w_grant,
  output logic              w_timeout,
  output logic              w_dram_le,
  output logic [ADDR_W-1:0] w_dram_addr,
  output logic              w_dram_we,
  output logic [DATA_W-1:0] w_dram_wdata,
  output logic [2:0]        w_dram_ctrl,
  input  logic              w_dram_busy,
  input  logic [DATA_W-1:0] w_dram_odata
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [1:0]        state;
  logic              rr_ptr;     // 0: CPU preferred next, 1: DMA preferred next
  logic [WD_W-1:0]   wdog;
  logic [1:0]        rr_gnt;
  logic [1:0]        winner;
  logic              wd_expire;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_ctrl;

  m_rr_pick2 u_rr_pick2 (
    .req (w_req[2:1]),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    winner = ARB_NONE;
    if (w_req[0])       winner = ARB_PTE;
    else if (rr_gnt[0]) winner = ARB_CPU;
    else if (rr_gnt[1]) winner = ARB_DMA;
  end

  always_comb begin
    sel_addr  = w_addr0;
    sel_we    = w_we[0];
    sel_wdata = w_wdata0;
    sel_ctrl  = w_ctrl0;
    case (winner)
      ARB_CPU: begin
        sel_addr  = w_addr1;
        sel_we    = w_we[1];
        sel_wdata = w_wdata1;
        sel_ctrl  = w_ctrl1;
      end
      ARB_DMA: begin
        sel_addr  = w_addr2;
        sel_we    = w_we[2];
        sel_wdata = w_wdata2;
        sel_ctrl  = w_ctrl2;
      end
      default: ;
    endcase
  end

  // Expiry is evaluated at the end of the TIMEOUT-th WAIT cycle; a falling busy wins.
  assign wd_expire = (TIMEOUT != 0) && w_dram_busy && (wdog == WD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ARB_IDLE;
      rr_ptr       <= 1'b0;
      wdog         <= '0;
      w_ack        <= '0;
      w_rdata      <= '0;
      w_grant      <= ARB_NONE;
      w_timeout    <= 1'b0;
      w_dram_le    <= 1'b0;
      w_dram_addr  <= '0;
      w_dram_we    <= 1'b0;
      w_dram_wdata <= '0;
      w_dram_ctrl  <= '0;
    end else begin
      w_ack     <= '0;
      w_dram_le <= 1'b0;
      w_timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if ((|w_req) && !w_dram_busy) begin
            w_grant      <= winner;
            w_dram_addr  <= sel_addr;
            w_dram_we    <= sel_we;
            w_dram_wdata <= sel_wdata;
            w_dram_ctrl  <= sel_ctrl;
            w_dram_le    <= 1'b1;
            state        <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wdog  <= '0;
          state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (!w_dram_busy) begin
            w_rdata <= w_dram_odata;
            w_ack   <= arb_onehot(w_grant);
            state   <= ARB_DONE;
          end else if (wd_expire) begin
            w_timeout <= 1'b1;
            w_ack     <= arb_onehot(w_grant);
            w_rdata   <= '0;
            w_grant   <= ARB_NONE;
            state     <= ARB_IDLE;
          end else if (wdog != '1) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ARB_DONE: begin
          if (w_grant == ARB_CPU)      rr_ptr <= 1'b1;
          else if (w_grant == ARB_DMA) rr_ptr <= 1'b0;
          w_grant <= ARB_NONE;
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dram_port_arbiter.sv
// Self-checking bench for m_dram_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration, DRAM timing and completion.
module tb_m_dram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    w_req = '0;
  logic [AW-1:0] op_addr [3];
  logic [2:0]    op_we = '0;
  logic [DW-1:0] op_wdata [3];
  logic [2:0]    op_ctrl [3];
  logic [2:0]    w_ack;
  logic [DW-1:0] w_rdata;
  logic [1:0]    w_grant;
  logic          w_timeout;
  logic          w_dram_le;
  logic [AW-1:0] w_dram_addr;
  logic          w_dram_we;
  logic [DW-1:0] w_dram_wdata;
  logic [2:0]    w_dram_ctrl;
  logic          w_dram_busy = 1'b0;
  logic [DW-1:0] w_dram_odata = '0;

  always #5 CLK = ~CLK;

  m_dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .w_req(w_req),
    .w_addr0(op_addr[0]), .w_addr1(op_addr[1]), .w_addr2(op_addr[2]),
    .w_we(op_we),
    .w_wdata0(op_wdata[0]), .w_wdata1(op_wdata[1]), .w_wdata2(op_wdata[2]),
    .w_ctrl0(op_ctrl[0]), .w_ctrl1(op_ctrl[1]), .w_ctrl2(op_ctrl[2]),
    .w_ack(w_ack), .w_rdata(w_rdata), .w_grant(w_grant), .w_timeout(w_timeout),
    .w_dram_le(w_dram_le), .w_dram_addr(w_dram_addr), .w_dram_we(w_dram_we),
    .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  int            cyc = 0;
  bit            outstanding = 0;
  int            owner_m = 3;
  int            le_cyc = 0, ack_cyc = 0, n_le = 0, total_acks = 0;
  bit            ptr_dma = 0;
  logic [DW-1:0] exp_data = '0;
  logic [AW-1:0] sv_addr;
  logic [DW-1:0] sv_wdata;
  logic          sv_we;
  logic [2:0]    sv_ctrl;
  int            busy_left = 0, next_len = 0;
  bit            stuck = 0, next_fixed = 0;
  logic [DW-1:0] next_data = '0;
  int            order[$];
  int            rereq [3] = '{0, 0, 0};

  function automatic int model_winner(input logic [2:0] r);
    if (r[0]) return 0;
    if (r[1] && r[2]) return ptr_dma ? 2 : 1;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] exp_ack(input int p);
    logic [2:0] v;
    v = '0;
    if (p >= 0 && p < 3) v[p] = 1'b1;
    return v;
  endfunction

  task automatic new_ops(input int p);
    op_addr[p]  = $urandom;
    op_wdata[p] = $urandom;
    op_ctrl[p]  = 3'($urandom_range(0, 7));
    op_we[p]    = 1'($urandom_range(0, 1));
  endtask

  task automatic cycle();
    int win;
    @(posedge CLK);
    #1;
    cyc++;
    if (w_dram_le) begin
      win = model_winner(w_req);
      n_le++;
      check("le_while_busy_txn", 64'(outstanding), 0);
      check("grant_at_le", w_grant, 64'(win));
      if (win < 3) begin
        check("dram_addr", w_dram_addr, op_addr[win]);
        check("dram_we", w_dram_we, op_we[win]);
        check("dram_wdata", w_dram_wdata, op_wdata[win]);
        check("dram_ctrl", w_dram_ctrl, op_ctrl[win]);
        sv_addr = op_addr[win]; sv_we = op_we[win];
        sv_wdata = op_wdata[win]; sv_ctrl = op_ctrl[win];
      end
      owner_m = win; le_cyc = cyc; outstanding = 1;
      exp_data = next_fixed ? next_data : $urandom;
      next_fixed = 0;
      busy_left = stuck ? 1000 : (next_len > 0 ? next_len : $urandom_range(1, 5));
      next_len = 0;
    end else if (outstanding && w_ack == 3'b000) begin
      check("grant_hold", w_grant, 64'(owner_m));
      check("dram_regs_hold", {w_dram_addr, w_dram_wdata}, {sv_addr, sv_wdata});
    end
    if (w_ack != 3'b000) begin
      check("ack_owner", w_ack, outstanding ? exp_ack(owner_m) : 3'b000);
      check("timeout_with_ack", 64'(w_timeout), 64'(stuck));
      check("rdata", w_rdata, stuck ? '0 : exp_data);
      ack_cyc = cyc;
      total_acks++;
      order.push_back(owner_m);
      if (!stuck && owner_m != 0) ptr_dma = (owner_m == 1);
      if (owner_m < 3) begin
        w_req[owner_m] = 1'b0;
        if (rereq[owner_m] > 0) begin
          rereq[owner_m]--;
          new_ops(owner_m);
          w_req[owner_m] = 1'b1;
        end
      end
      outstanding = 0;
    end else if (w_timeout) begin
      check("timeout_without_ack", 64'(w_timeout), 0);
    end
    // DRAM controller model: busy from the cycle after le for busy_left cycles
    if (busy_left > 0 && cyc > le_cyc) begin
      w_dram_busy = 1'b1;
      busy_left--;
    end else if (w_dram_busy && !stuck && busy_left == 0) begin
      w_dram_busy  = 1'b0;
      w_dram_odata = exp_data;
    end
  endtask

  task automatic wait_acks(input int n, input string tag);
    int start;
    int k;
    start = total_acks;
    k = 0;
    while (total_acks < start + n && k < 200) begin
      cycle();
      k++;
    end
    check(tag, 64'(total_acks - start), 64'(n));
  endtask

  task automatic wait_le(input string tag);
    int k;
    k = 0;
    while (!outstanding && k < 20) begin
      cycle();
      k++;
    end
    check(tag, 64'(outstanding), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int req_cyc;
    int le_before;
    for (int p = 0; p < 3; p++) new_ops(p);
    op_we = '0;

    cycle(); cycle();
    check("rst_grant", w_grant, 2'd3);
    check("rst_ack", w_ack, 3'b000);
    check("rst_le", w_dram_le, 0);
    check("rst_timeout", w_timeout, 0);
    check("rst_rdata", w_rdata, 0);
    check("rst_dram", {w_dram_addr, w_dram_we, w_dram_wdata, w_dram_ctrl}, 0);
    RST = 1'b0;
    cycle();

    // CPU and DMA held together: alternate starting with CPU
    order.delete();
    new_ops(1); new_ops(2);
    rereq[1] = 1; rereq[2] = 1;
    w_req[1] = 1'b1; w_req[2] = 1'b1;
    wait_acks(4, "rr_acks");
    check("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]},
          {4'd1, 4'd2, 4'd1, 4'd2});
    repeat (2) cycle();

    // Single CPU read
    op_addr[1] = 32'h8000_1000; op_we[1] = 1'b0; op_ctrl[1] = 3'b010;
    next_len = 4; next_fixed = 1; next_data = 32'hDEAD_BEEF;
    req_cyc = cyc;
    w_req[1] = 1'b1;
    wait_acks(1, "t1_ack");
    check("t1_rdata", w_rdata, 32'hDEAD_BEEF);
    check("t1_le_lat", 64'(le_cyc - req_cyc), 1);
    check("t1_ack_lat", 64'(ack_cyc - req_cyc), 7);
    cycle();
    check("t1_idle_grant", w_grant, 2'd3);

    // PTE beats CPU, PTE re-request in its ack cycle still beats CPU
    order.delete();
    new_ops(0); new_ops(1);
    rereq[0] = 1;
    w_req[0] = 1'b1; w_req[1] = 1'b1;
    wait_acks(3, "pte_acks");
    check("pte_order", {order[0][3:0], order[1][3:0], order[2][3:0]}, {4'd0, 4'd0, 4'd1});
    cycle();

    // PTE write-back; operands change mid-WAIT and must not reach the DRAM regs
    op_we[0] = 1'b1; op_wdata[0] = 32'h0000_00C1; op_addr[0] = 32'h0001_2340;
    next_len = 5;
    w_req[0] = 1'b1;
    wait_le("t4_le");
    cycle();
    op_wdata[0] = 32'h1234_5678;
    wait_acks(1, "t4_ack");
    check("t4_we", w_dram_we, 1);
    check("t4_wdata", w_dram_wdata, 32'h0000_00C1);
    op_we[0] = 1'b0;
    cycle();

    // Watchdog with DRAM stuck busy, then busy-in-IDLE blocks the next grant
    stuck = 1;
    new_ops(1);
    w_req[1] = 1'b1;
    wait_acks(1, "t5_ack");
    check("t5_to_lat", 64'(ack_cyc - le_cyc), 64'(TO + 1));
    new_ops(2);
    w_req[2] = 1'b1;
    le_before = n_le;
    repeat (4) cycle();
    check("t5_blocked", 64'(n_le - le_before), 0);
    stuck = 0; busy_left = 0;
    wait_acks(1, "t5_after_ack");
    check("t5_after_owner", 64'(order[$]), 2);
    cycle();

    // Reset in the middle of WAIT
    next_len = 6;
    new_ops(1);
    w_req[1] = 1'b1;
    wait_le("t6_le");
    cycle(); cycle();
    #2 RST = 1'b1;
    #1;
    check("t6_grant", w_grant, 2'd3);
    check("t6_ack", w_ack, 3'b000);
    check("t6_le", w_dram_le, 0);
    check("t6_rdata", w_rdata, 0);
    check("t6_dram", {w_dram_addr, w_dram_we, w_dram_wdata, w_dram_ctrl}, 0);
    w_req = '0; outstanding = 0; ptr_dma = 0; busy_left = 0; w_dram_busy = 1'b0;
    cycle(); cycle();
    RST = 1'b0;
    next_len = 2;
    new_ops(1);
    w_req[1] = 1'b1;
    wait_acks(1, "t6_fresh_ack");
    check("t6_fresh_owner", 64'(order[$]), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle();
      for (int p = 0; p < 3; p++) begin
        if (!w_req[p] && $urandom_range(0, 3) == 0) begin
          new_ops(p);
          w_req[p] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 200 && (w_req != 3'b000 || outstanding); k++) cycle();
    check("drain", {w_req, 3'(outstanding)}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
